// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared washing-machine state encoding and phase durations
package wm_pkg;

    localparam int PERIOD_W = 16;
    localparam int FILL_T   = 1;
    localparam int WASH_T   = 5;
    localparam int RINSE_T  = 2;
    localparam int SPIN_T   = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4
    } wm_state_e;

endpackage

// File: rtl/wash_cycle_ctrl.sv
// rtl/wash_cycle_ctrl.sv - paid wash-cycle sequencer driving the shared phase timer
module wash_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int PERIOD_W = wm_pkg::PERIOD_W,
    parameter int FILL_T   = wm_pkg::FILL_T,
    parameter int WASH_T   = wm_pkg::WASH_T,
    parameter int RINSE_T  = wm_pkg::RINSE_T,
    parameter int SPIN_T   = wm_pkg::SPIN_T
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_in,
    input  logic                double_wash,
    input  logic                lid_open,
    input  logic                cancel,
    input  logic                tmr_done,
    output logic                tmr_clear,
    output logic                tmr_enable,
    output logic [PERIOD_W-1:0] tmr_period,
    output logic [2:0]          state,
    output logic                wash_done
);

    wm_state_e           state_q, state_d, nxt;
    logic                entry_q, entry_d;
    logic                pass_q, pass_d;
    logic                dbl_q, dbl_d;
    logic                clr_q, clr_d;
    logic                en_q, en_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic                done_q, done_d;

    function automatic logic [PERIOD_W-1:0] phase_period(input wm_state_e s);
        case (s)
            ST_FILL:  return PERIOD_W'(FILL_T);
            ST_WASH:  return PERIOD_W'(WASH_T);
            ST_RINSE: return PERIOD_W'(RINSE_T);
            ST_SPIN:  return PERIOD_W'(SPIN_T);
            default:  return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            entry_q <= 1'b0;
            pass_q  <= 1'b0;
            dbl_q   <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            per_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            pass_q  <= pass_d;
            dbl_q   <= dbl_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        pass_d  = pass_q;
        dbl_d   = dbl_q;
        clr_d   = 1'b0;
        en_d    = 1'b0;
        per_d   = per_q;
        done_d  = 1'b0;
        nxt     = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                per_d = '0;
                if (coin_in) begin
                    state_d = ST_FILL;
                    entry_d = 1'b1;
                    clr_d   = 1'b1;
                    per_d   = phase_period(ST_FILL);
                    dbl_d   = double_wash;
                    pass_d  = 1'b0;
                end
            end
            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    per_d   = '0;
                end else if (entry_q) begin
                    en_d = 1'b1;
                end else if (state_q == ST_SPIN && lid_open) begin
                    // paused: timer keeps its count, no re-clear on release
                    en_d = 1'b0;
                end else if (en_q && tmr_done) begin
                    case (state_q)
                        ST_FILL:  nxt = ST_WASH;
                        ST_WASH:  nxt = ST_RINSE;
                        ST_RINSE: begin
                            if (dbl_q && !pass_q) begin
                                nxt    = ST_WASH;
                                pass_d = 1'b1;
                            end else begin
                                nxt = ST_SPIN;
                            end
                        end
                        default:  nxt = ST_IDLE;
                    endcase
                    if (nxt == ST_IDLE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        per_d   = '0;
                    end else begin
                        state_d = nxt;
                        entry_d = 1'b1;
                        clr_d   = 1'b1;
                        per_d   = phase_period(nxt);
                    end
                end else begin
                    en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                per_d   = '0;
            end
        endcase
    end

    assign tmr_clear  = clr_q;
    assign tmr_enable = en_q;
    assign tmr_period = per_q;
    assign state      = state_q;
    assign wash_done  = done_q;

endmodule
